// File: rtl/display_pkg.sv
// display_pkg: shared states, segment constants and glyph decode for the display path
package display_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam int DIGITS = 4;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] GLYPH [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    // Codes 10..15 never come out of a valid BCD digit; show nothing for them
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        return d < 4'd10 ? GLYPH[d] : SEG_BLANK;
    endfunction
endpackage

// File: rtl/module_bin2bcd.sv
// module_bin2bcd: sequential 16-bit binary to 5-digit BCD converter (shift-add-3)
module module_bin2bcd
    import display_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd
);
    state_t state, state_n;
    logic [15:0] sr;
    logic [3:0] cnt;
    logic [19:0] adj;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state == IDLE  ? (start ? SHIFT : IDLE) :
                  state == SHIFT ? (cnt == 4'd15 ? DONE : SHIFT) : IDLE;
        adj = bcd;
        for (int i = 0; i < 5; i++)
            adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sr <= '0;
            bcd <= '0;
            cnt <= '0;
        end else if (state == IDLE && start) begin
            sr <= bin;
            bcd <= '0;
            cnt <= '0;
        end else if (state == SHIFT) begin
            bcd <= {adj[18:0], sr[15]};
            sr <= {sr[14:0], 1'b0};
            cnt <= cnt + 4'd1;
        end
    assign busy = state != IDLE;
    assign done = state == DONE;
endmodule

// File: rtl/module_display_scan.sv
// module_display_scan: converts a 16-bit value to BCD and scans it onto a 4-digit 7-segment display
module module_display_scan
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 27000,
    parameter bit BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] numero_in,
    output logic        busy_o,
    output logic        done_o,
    output logic [3:0]  anodo_po,
    output logic [6:0]  seg_po
);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam logic [RW-1:0] RMAX = RW'(REFRESH_DIV - 1);
    logic [15:0] last_val;
    logic [19:0] digs, digs_n, bcd;
    logic [RW-1:0] rcnt;
    logic [IW-1:0] idx, idx_n;
    logic start, bcd_done, wrap, lz;
    logic [3:0] digit;
    logic [6:0] seg_n;
    module_bin2bcd u_bin2bcd (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(numero_in),
        .busy(busy_o), .done(bcd_done), .bcd(bcd)
    );
    // Decode from the next-state digits so a new value lands on the done edge, never mid-slot later
    always_comb begin
        start = !busy_o && numero_in != last_val;
        wrap = rcnt == RMAX;
        idx_n = idx + IW'(wrap);
        digs_n = bcd_done ? bcd : digs;
        digit = digs_n[{idx_n, 2'b00} +: 4];
        lz = BLANK_LZ && idx_n != '0 && (digs_n[15:0] >> {idx_n, 2'b00}) == 16'd0;
        seg_n = digs_n[19:16] != 4'd0 ? SEG_DASH : lz ? SEG_BLANK : seg_of(digit);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            last_val <= '0;
            digs <= '0;
            rcnt <= '0;
            idx <= '0;
            done_o <= 1'b0;
            anodo_po <= 4'b1110;
            seg_po <= GLYPH[0];
        end else begin
            if (start) last_val <= numero_in;
            digs <= digs_n;
            rcnt <= wrap ? '0 : rcnt + 1'b1;
            idx <= idx_n;
            done_o <= bcd_done;
            anodo_po <= ~(4'b0001 << idx_n);
            seg_po <= seg_n;
        end
endmodule

// File: tb/tb_module_display_scan.sv
// tb_module_display_scan: scoreboard bench for conversion latency, scan order, blanking and overflow
module tb_module_display_scan;
    logic clk = 0, rst_n = 0;
    logic [15:0] numero = 0;
    logic busy_o, done_o, busy_f, done_f;
    logic [3:0] anodo_po, anodo_f;
    logic [6:0] seg_po, seg_f;
    int n_checks = 0, n_fail = 0, cyc = 0;
    typedef struct {string tag; bit full; logic [3:0] an; logic [6:0] seg;} exp_t;
    exp_t sbq[$];

    module_display_scan #(.REFRESH_DIV(4), .BLANK_LZ(1)) dut (
        .clk(clk), .rst_n(rst_n), .numero_in(numero), .busy_o(busy_o),
        .done_o(done_o), .anodo_po(anodo_po), .seg_po(seg_po));
    module_display_scan #(.REFRESH_DIV(4), .BLANK_LZ(0)) dut_full (
        .clk(clk), .rst_n(rst_n), .numero_in(numero), .busy_o(busy_f),
        .done_o(done_f), .anodo_po(anodo_f), .seg_po(seg_f));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input bit full, input logic [3:0] an, input logic [6:0] sg);
        exp_t e;
        e.tag = tag; e.full = full; e.an = an; e.seg = sg;
        sbq.push_back(e);
    endtask

    task automatic push4(input string tag, input bit full, input logic [6:0] s0, s1, s2, s3);
        push(tag, full, 4'b1110, s0);
        push(tag, full, 4'b1101, s1);
        push(tag, full, 4'b1011, s2);
        push(tag, full, 4'b0111, s3);
    endtask

    task automatic drain();
        while (sbq.size() > 0) begin
            exp_t e;
            int t;
            logic [3:0] an;
            e = sbq.pop_front();
            t = 0;
            do begin
                @(negedge clk);
                t++;
                an = e.full ? anodo_f : anodo_po;
            end while (an != e.an && t < 64);
            check({e.tag, "_an"}, an, e.an);
            check({e.tag, "_seg"}, e.full ? seg_f : seg_po, e.seg);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done_o && n < 60);
    endtask

    task automatic set_val(input logic [15:0] v, output int n);
        @(posedge clk);
        #1 numero = v;
        wait_done(n);
    endtask

    function automatic logic [6:0] g1234(input logic [3:0] an);
        case (an)
            4'b1110: return 7'b0011001;
            4'b1101: return 7'b0110000;
            4'b1011: return 7'b0100100;
            4'b0111: return 7'b1111001;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    initial begin
        int n, nd, t1;
        repeat (2) @(negedge clk);
        check("rst_an", anodo_po, 4'b1110);
        check("rst_seg", seg_po, 7'b1000000);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        rst_n = 1;
        nd = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_o) nd++;
        end
        check("idle_no_done", nd, 0);

        set_val(16'd1234, n);
        check("lat_1234", n, 18);
        @(posedge clk);
        #1 check("done_pulse", done_o, 0);
        push4("v1234", 0, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);
        drain();

        set_val(16'd7, n);
        check("lat_7", n, 18);
        push4("v7_lz", 0, 7'b1111000, 7'b1111111, 7'b1111111, 7'b1111111);
        push4("v7_full", 1, 7'b1111000, 7'b1000000, 7'b1000000, 7'b1000000);
        drain();

        set_val(16'd65025, n);
        check("lat_ovf", n, 18);
        push4("ovf", 0, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111);
        drain();

        @(posedge clk);
        #1 numero = 16'd1234;
        repeat (6) @(posedge clk);
        #1 numero = 16'd42;
        wait_done(n);
        check("mid_lat", n, 12);
        t1 = cyc;
        check("mid_idle", busy_o, 0);
        @(posedge clk);
        #1 check("mid_restart", busy_o, 1);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("mid_1234", seg_po, g1234(anodo_po));
        end
        wait_done(n);
        check("mid_lat2", cyc - t1, 18);
        push4("v42", 0, 7'b0100100, 7'b0011001, 7'b1111111, 7'b1111111);
        drain();

        @(posedge clk);
        #1 numero = 16'd9999;
        repeat (11) @(posedge clk);
        #1 rst_n = 0;
        #1;
        check("rr_an", anodo_po, 4'b1110);
        check("rr_seg", seg_po, 7'b1000000);
        check("rr_busy", busy_o, 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        wait_done(n);
        check("rr_lat", n, 18);
        push4("v9999", 0, 7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/module_display_scan.md
Name: module_display_scan

Overview:
- Consumer end of the display path: takes the selected 16-bit binary value from the priority selector and drives a 4-digit multiplexed 7-segment display.
- Converts binary to BCD sequentially (shift-add-3), holds the digits in a register, and scans the anodes at a fixed refresh rate.
- Sits between the selector output and the board pins.

Parameters:
- REFRESH_DIV, 27000, clk cycles per digit slot (1 kHz per digit at 27 MHz).
- BLANK_LZ, 1, 1 = blank leading zeros; 0 = show all four digits.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- numero_in  input  16  unsigned binary value to display.
- busy_o  output  1  high while a conversion is in progress.
- done_o  output  1  one-cycle pulse when the new digits are loaded.
- anodo_po  output  4  digit enables, active-low, bit0 = units (rightmost).
- seg_po  output  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset (async assert, sync release) state:
  - state = IDLE; last_val = 0; digit register = 0000; scan index = 0; refresh counter = 0.
  - busy_o = 0, done_o = 0, anodo_po = 4'b1110, seg_po = 7'b1000000 (glyph '0').
- State machine:
  - IDLE: when numero_in != last_val, capture numero_in into the shift register and last_val, clear the 20-bit BCD accumulator, and move to SHIFT with bit count 0.
  - SHIFT: one bit per edge for 16 edges. Each edge, add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1. After the 16th shift, move to DONE.
  - DONE: load the digit register from the accumulator, pulse done_o, return to IDLE.
- Latency:
  - Capture at edge k, shifts at edges k+1..k+16, digits loaded at k+17, done_o high in the cycle after k+17.
  - busy_o is high from k+1 until DONE exits.
- Input changes while busy are ignored. The IDLE compare on return re-triggers a conversion, so the display always converges to the final stable value. No request is lost or queued beyond one.
- A stable input never retriggers, so done_o stays 0.
- Overflow: if the ten-thousands BCD digit is nonzero (value > 9999), all four digits show a dash (seg_po = 7'b0111111).
- Blanking with BLANK_LZ = 1:
  - Digits above the most significant nonzero digit show blank (7'b1111111).
  - The units digit is never blanked, so value 0 shows a single '0'.
- Scan:
  - The refresh counter runs 0..REFRESH_DIV-1 and wraps. On wrap, the scan index advances 0→1→2→3→0.
  - anodo_po = ~(4'b0001 << index), registered. seg_po is the registered decode of the selected digit, in the same cycle as anodo_po.
  - Exactly one anode is low at all times after reset.
  - The scan runs independently of conversions. A digit register update is visible at the next scan slot of each digit with no glitch inside a slot: seg_po may change mid-slot only on the done edge.
- Decoder:
  - Digits 0–9 use the standard glyphs.
  - Digits 10–15 cannot occur. Decode them to blank.
- Reset mid-conversion abandons the conversion. The display returns to '0' and last_val = 0, so a nonzero numero_in held through reset converts immediately after release.

Decomposition:
- Package display_pkg holds:
  - state enum {IDLE, SHIFT, DONE};
  - segment constants SEG_BLANK, SEG_DASH;
  - the 10-entry active-low glyph table;
  - the DIGITS = 4 constant.
- Sub-module module_bin2bcd: the sequential double-dabble unit with start/busy/done and a 20-bit BCD output. The top level keeps the compare/trigger logic, overflow/blanking, refresh counter, anode and segment registers.

Test Plan:
- Reset with REFRESH_DIV = 4, numero_in = 0 → anodo_po = 1110, seg_po = 1000000; no done_o pulse over 200 cycles.
- numero_in = 1234 (0x04D2) → done_o exactly 18 cycles after the change. Scan slots 0..3 show 4, 3, 2, 1: seg_po = 0011001, 0110000, 0100100, 1111001, with anodo_po 1110, 1101, 1011, 0111.
- numero_in = 7, BLANK_LZ = 1 → units shows 1111000; digits 1–3 show 1111111. With BLANK_LZ = 0 → digits 1–3 show 1000000.
- numero_in = 65025 (multiplier max) → all four slots show seg_po = 0111111.
- Change 1234 → 42 at SHIFT bit 5 → the first conversion completes (done_o pulse, shows 1234). A second conversion starts on the next IDLE cycle; the display then shows 42 blank-padded.
- Assert rst_n low at SHIFT bit 10 of 9999, release with numero_in = 9999 held → display shows '0' during reset, then 9999 after 18 cycles.
